// File: rtl/sclk_rate_monitor_if.sv
// Bundle of SCLK monitor signals: the monitored clock and clear in, measurement/status out.
// HP_MIN/HP_MAX exist only when SCLK_MON_MINMAX_EN is defined.
interface sclk_rate_monitor_if;
   logic        SCLK_IN;
   logic        CLR;
   logic        EDGE_STB;
   logic [31:0] HALF_PERIOD;
   logic [2:0]  RATE_CODE;
   logic        LOCKED;
   logic        STALLED;
   logic        MATCH_ERR;
`ifdef SCLK_MON_MINMAX_EN
   logic [31:0] HP_MIN;
   logic [31:0] HP_MAX;
`endif

   modport master (
      output SCLK_IN, CLR,
      input  EDGE_STB, HALF_PERIOD, RATE_CODE, LOCKED, STALLED, MATCH_ERR
`ifdef SCLK_MON_MINMAX_EN
      , input HP_MIN, HP_MAX
`endif
   );

   modport slave (
      input  SCLK_IN, CLR,
      output EDGE_STB, HALF_PERIOD, RATE_CODE, LOCKED, STALLED, MATCH_ERR
`ifdef SCLK_MON_MINMAX_EN
      , output HP_MIN, HP_MAX
`endif
   );
endinterface

// File: rtl/sclk_rate_monitor.sv
// Measures the half-period of an asynchronous SCLK in CLK cycles, decodes the 3-bit rate
// code, and reports lock/stall. SCLK_MON_MINMAX_EN adds min/max half-period tracking.
module sclk_rate_monitor #(
   parameter int unsigned BASE_HALF  = 50000000,
   parameter int unsigned TOL_SHIFT  = 4,
   parameter int unsigned LOCK_COUNT = 3,
   parameter int unsigned TIMEOUT    = 4 * (BASE_HALF + 1)
) (
   input  logic               CLK,
   input  logic               RST_N,
   sclk_rate_monitor_if.slave mon
);
   localparam int MCW = $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {IDLE, MEASURE, LOCK, STALL} state_e;

   state_e         state_q, state_d;
   logic           s1_q, s2_q, s3_q;
   logic           edge_q, edge_d;
   logic [31:0]    cnt_q, cnt_d;
   logic [31:0]    hp_q, hp_d;
   logic [2:0]     code_q, code_d;
   logic [2:0]     last_q, last_d;
   logic [MCW-1:0] mcnt_q, mcnt_d, mcnt_inc;
   logic           err_q, err_d;
   logic [33:0]    meas;
   logic           hit;
   logic [2:0]     hit_code;
`ifdef SCLK_MON_MINMAX_EN
   logic [31:0]    min_q, min_d, max_q, max_d;
`endif

   function automatic logic in_window(input logic [33:0] m, input int n);
      logic [33:0] tgt, tol;
      tgt = {2'b0, BASE_HALF >> n} + 34'd1;
      tol = {2'b0, (BASE_HALF >> n) >> TOL_SHIFT};
      return (m + tol >= tgt) && (m <= tgt + tol);
   endfunction

   // Walk downward so the lowest matching code is the one left standing.
   always_comb begin
      meas     = {2'b0, cnt_q} + 34'd1;
      hit      = 1'b0;
      hit_code = '0;
      for (int n = 7; n >= 0; n--) begin
         if (in_window(meas, n)) begin
            hit      = 1'b1;
            hit_code = 3'(n);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      edge_d  = s2_q ^ s3_q;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
      hp_d    = hp_q;
      code_d  = code_q;
      last_d  = last_q;
      mcnt_d  = mcnt_q;
      err_d   = 1'b0;
`ifdef SCLK_MON_MINMAX_EN
      min_d   = min_q;
      max_d   = max_q;
`endif
      if (mcnt_q != '0 && hit_code == last_q)
         mcnt_inc = (mcnt_q == MCW'(LOCK_COUNT)) ? mcnt_q : mcnt_q + 1'b1;
      else
         mcnt_inc = MCW'(1);

      if (edge_q) begin
         cnt_d = '0;
         case (state_q)
            IDLE, STALL: state_d = MEASURE;
            default: begin
               hp_d = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
`ifdef SCLK_MON_MINMAX_EN
               if (hp_d < min_q) min_d = hp_d;
               if (hp_d > max_q) max_d = hp_d;
`endif
               if (!hit) begin
                  err_d   = 1'b1;
                  mcnt_d  = '0;
                  state_d = MEASURE;
               end else begin
                  mcnt_d = mcnt_inc;
                  last_d = hit_code;
                  if (state_q == MEASURE && mcnt_inc == MCW'(LOCK_COUNT)) begin
                     state_d = LOCK;
                     code_d  = hit_code;
                  end else if (state_q == LOCK && hit_code != last_q) begin
                     state_d = MEASURE;
                  end
               end
            end
         endcase
      end else if (state_q != STALL && cnt_d >= TIMEOUT - 1) begin
         state_d = STALL;
         mcnt_d  = '0;
      end

      // Clear leaves the synchronizer alone so a level change in flight is not lost.
      if (mon.CLR) begin
         state_d = IDLE;
         edge_d  = 1'b0;
         cnt_d   = '0;
         hp_d    = '0;
         code_d  = '0;
         last_d  = '0;
         mcnt_d  = '0;
         err_d   = 1'b0;
`ifdef SCLK_MON_MINMAX_EN
         min_d   = '1;
         max_d   = '0;
`endif
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         state_q <= IDLE;
         edge_q  <= 1'b0;
         cnt_q   <= '0;
         hp_q    <= '0;
         code_q  <= '0;
         last_q  <= '0;
         mcnt_q  <= '0;
         err_q   <= 1'b0;
`ifdef SCLK_MON_MINMAX_EN
         min_q   <= '1;
         max_q   <= '0;
`endif
      end else begin
         s1_q    <= mon.SCLK_IN;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         state_q <= state_d;
         edge_q  <= edge_d;
         cnt_q   <= cnt_d;
         hp_q    <= hp_d;
         code_q  <= code_d;
         last_q  <= last_d;
         mcnt_q  <= mcnt_d;
         err_q   <= err_d;
`ifdef SCLK_MON_MINMAX_EN
         min_q   <= min_d;
         max_q   <= max_d;
`endif
      end
   end

   assign mon.EDGE_STB    = edge_q;
   assign mon.HALF_PERIOD = hp_q;
   assign mon.RATE_CODE   = code_q;
   assign mon.LOCKED      = (state_q == LOCK);
   assign mon.STALLED     = (state_q == STALL);
   assign mon.MATCH_ERR   = err_q;
`ifdef SCLK_MON_MINMAX_EN
   assign mon.HP_MIN      = min_q;
   assign mon.HP_MAX      = max_q;
`endif
endmodule

// File: tb/tb_sclk_rate_monitor.sv
// Directed bench for sclk_rate_monitor: lock, relock, stall, no-match, reset/clear,
// and min/max tracking when SCLK_MON_MINMAX_EN is defined.
module tb_sclk_rate_monitor;
   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   logic e2, e3, e4, r4, r5;

   sclk_rate_monitor_if mon ();

   sclk_rate_monitor #(
      .BASE_HALF(64), .TOL_SHIFT(3), .LOCK_COUNT(3), .TIMEOUT(260)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .mon(mon)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Toggle SCLK_IN, then hold for n CLK; records EDGE_STB and MATCH_ERR around the edge.
   task automatic half(input int n);
      mon.SCLK_IN = ~mon.SCLK_IN;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (k == 2) e2 = mon.EDGE_STB;
         if (k == 3) e3 = mon.EDGE_STB;
         if (k == 4) begin e4 = mon.EDGE_STB; r4 = mon.MATCH_ERR; end
         if (k == 5) r5 = mon.MATCH_ERR;
      end
   endtask

   initial begin
      mon.SCLK_IN = 1'b0;
      mon.CLR     = 1'b0;
      repeat (3) tick();
      chk("rst_edge",   32'(mon.EDGE_STB), 0);
      chk("rst_hp",     mon.HALF_PERIOD, 0);
      chk("rst_code",   32'(mon.RATE_CODE), 0);
      chk("rst_locked", 32'(mon.LOCKED), 0);
      chk("rst_stall",  32'(mon.STALLED), 0);
      chk("rst_err",    32'(mon.MATCH_ERR), 0);
      RST_N = 1'b1;
      repeat (2) tick();

      // Lock at code 0
      half(65);
      chk("t1_e2", 32'(e2), 0);
      chk("t1_e3", 32'(e3), 1);
      chk("t1_e4", 32'(e4), 0);
      chk("t1_arm_hp", mon.HALF_PERIOD, 0);
      chk("t1_arm_lk", 32'(mon.LOCKED), 0);
      half(65);
      chk("t1_m1_hp", mon.HALF_PERIOD, 65);
      chk("t1_m1_lk", 32'(mon.LOCKED), 0);
      half(65);
      chk("t1_m2_lk", 32'(mon.LOCKED), 0);
      half(65);
      chk("t1_lk",   32'(mon.LOCKED), 1);
      chk("t1_code", 32'(mon.RATE_CODE), 0);
      chk("t1_hp",   mon.HALF_PERIOD, 65);
      chk("t1_err",  32'(r4), 0);

      // Rate change to code 2
      half(17);
      chk("t2_hold_lk", 32'(mon.LOCKED), 1);
      chk("t2_hold_hp", mon.HALF_PERIOD, 65);
      half(17);
      chk("t2_unlk",      32'(mon.LOCKED), 0);
      chk("t2_hp",        mon.HALF_PERIOD, 17);
      chk("t2_code_hold", 32'(mon.RATE_CODE), 0);
      half(17);
      chk("t2_m2_lk", 32'(mon.LOCKED), 0);
      half(17);
      chk("t2_relk", 32'(mon.LOCKED), 1);
      chk("t2_code", 32'(mon.RATE_CODE), 2);

      // Stall: edge strobe 3 CLK after toggle, stall 260 CLK after that
      repeat (245) tick();
      chk("t3_pre_stall", 32'(mon.STALLED), 0);
      chk("t3_pre_lk",    32'(mon.LOCKED), 1);
      tick();
      chk("t3_stall",  32'(mon.STALLED), 1);
      chk("t3_lk_off", 32'(mon.LOCKED), 0);
      half(9);
      chk("t3_unstall", 32'(mon.STALLED), 0);
      chk("t3_arm_lk",  32'(mon.LOCKED), 0);
      chk("t3_arm_hp",  mon.HALF_PERIOD, 17);
      half(9);
      half(9);
      chk("t3_m2_lk", 32'(mon.LOCKED), 0);
      half(9);
      chk("t3_lk",   32'(mon.LOCKED), 1);
      chk("t3_code", 32'(mon.RATE_CODE), 3);
      chk("t3_hp",   mon.HALF_PERIOD, 9);

      // No-match rate
      half(45);
      chk("t4_hold_lk", 32'(mon.LOCKED), 1);
      half(45);
      chk("t4_err",      32'(r4), 1);
      chk("t4_err_end",  32'(r5), 0);
      chk("t4_hp",       mon.HALF_PERIOD, 45);
      chk("t4_lk",       32'(mon.LOCKED), 0);
      chk("t4_code",     32'(mon.RATE_CODE), 3);
      half(9);
      chk("t4_err2", 32'(r4), 1);
      chk("t4_lk2",  32'(mon.LOCKED), 0);
      half(9);
      half(9);
      half(9);
      chk("t5_pre_lk", 32'(mon.LOCKED), 1);

      // Asynchronous reset mid-lock
      #2 RST_N = 1'b0;
      #1;
      chk("t5_rst_lk",   32'(mon.LOCKED), 0);
      chk("t5_rst_hp",   mon.HALF_PERIOD, 0);
      chk("t5_rst_code", 32'(mon.RATE_CODE), 0);
      repeat (2) tick();
      RST_N = 1'b1;
      repeat (2) tick();
      half(9);
      chk("t5_arm_hp", mon.HALF_PERIOD, 0);
      chk("t5_arm_lk", 32'(mon.LOCKED), 0);
      half(9);
      half(9);
      half(9);
      chk("t5_relk",  32'(mon.LOCKED), 1);
      chk("t5_code",  32'(mon.RATE_CODE), 3);

      // Synchronous clear
      mon.CLR = 1'b1;
      tick();
      mon.CLR = 1'b0;
      chk("t5_clr_lk",   32'(mon.LOCKED), 0);
      chk("t5_clr_hp",   mon.HALF_PERIOD, 0);
      chk("t5_clr_code", 32'(mon.RATE_CODE), 0);
      half(9);
      chk("t5_clr_e3",     32'(e3), 1);
      chk("t5_clr_arm_hp", mon.HALF_PERIOD, 0);
      half(9);
      chk("t5_clr_m_hp", mon.HALF_PERIOD, 9);

`ifdef SCLK_MON_MINMAX_EN
      mon.CLR = 1'b1;
      tick();
      mon.CLR = 1'b0;
      chk("t6_clr_min", mon.HP_MIN, 32'hFFFFFFFF);
      chk("t6_clr_max", mon.HP_MAX, 0);
      half(65);
      chk("t6_arm_min", mon.HP_MIN, 32'hFFFFFFFF);
      half(63);
      half(70);
      half(9);
      chk("t6_min", mon.HP_MIN, 63);
      chk("t6_max", mon.HP_MAX, 70);
      mon.CLR = 1'b1;
      tick();
      mon.CLR = 1'b0;
      chk("t6_clr2_min", mon.HP_MIN, 32'hFFFFFFFF);
      chk("t6_clr2_max", mon.HP_MAX, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
